// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/grant bundle between CiM/master requesters and the arbiter.
// Modports: master = arbiter side (drives grant/status), slave = requester side.
interface bus_arbiter_if #(
  parameter int NUM_CIMS = 64
);
  localparam int NUM_REQ = NUM_CIMS + 1;
  localparam int IW      = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [IW-1:0]      owner_idx;
  logic               timeout_pulse;

  modport master (
    input  req,
    output grant,
    output grant_valid,
    output owner_idx,
    output timeout_pulse
  );

  modport slave (
    output req,
    input  grant,
    input  grant_valid,
    input  owner_idx,
    input  timeout_pulse
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: non-preemptive bus arbiter, master fixed priority, CiMs round-robin,
// one idle TURNAROUND cycle between owners. Ports: clk, rst (async high),
// bus (bus_arbiter_if.master: req in; grant, grant_valid, owner_idx, timeout_pulse out).
// Optional macro BUS_ARB_TIMEOUT_EN: forced revoke after MAX_HOLD cycles if others wait.
module bus_arbiter #(
  parameter int NUM_CIMS = 64,
  parameter int MAX_HOLD = 128
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_if.master  bus
);
  localparam int NUM_REQ = NUM_CIMS + 1;
  localparam int IW      = $clog2(NUM_REQ);
  localparam int KW      = IW + 1;

  if (NUM_CIMS < 1 || MAX_HOLD < 2) begin : g_bad_params
    $error("bus_arbiter: NUM_CIMS must be >= 1 and MAX_HOLD >= 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    GRANTED,
    TURNAROUND
  } state_t;

  state_t             state;
  logic [NUM_REQ-1:0] grant_q;
  logic               gv_q;
  logic [IW-1:0]      owner_q;
  logic [IW-1:0]      cur_idx;
  logic [IW-1:0]      last_cim;
  logic [NUM_REQ-1:0] req_eff;
  logic               revoke;
  logic               win_ok;
  logic [IW-1:0]      win_idx;
  logic [KW-1:0]      k;

  assign bus.grant       = grant_q;
  assign bus.grant_valid = gv_q;
  assign bus.owner_idx   = owner_q;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0]      hold_cnt;
  logic               pulse_q;
  logic [NUM_REQ-1:0] own_mask;
  logic               others;

  assign own_mask = NUM_REQ'(1) << cur_idx;
  assign others   = |(bus.req & ~own_mask);
  assign revoke   = (state == GRANTED) && bus.req[cur_idx]
                  && (hold_cnt == CW'(MAX_HOLD - 1)) && others;
  assign bus.timeout_pulse = pulse_q;

  // A revoked owner still holds req; keep it out of the very next
  // arbitration so a timed-out master cannot win straight back.
  always_comb begin
    req_eff = bus.req;
    if (pulse_q) req_eff[cur_idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= revoke;
      if (state != GRANTED)
        hold_cnt <= '0;
      else if (hold_cnt != CW'(MAX_HOLD - 1))
        hold_cnt <= hold_cnt + CW'(1);
    end
  end
`else
  assign revoke            = 1'b0;
  assign bus.timeout_pulse = 1'b0;
  assign req_eff           = bus.req;
`endif

  // Winner: master first, else first CiM at or after last_cim+1 (wrapping).
  always_comb begin
    win_ok  = 1'b0;
    win_idx = '0;
    k       = '0;
    if (req_eff[NUM_CIMS]) begin
      win_ok  = 1'b1;
      win_idx = IW'(NUM_CIMS);
    end else begin
      for (int i = 0; i < NUM_CIMS; i++) begin
        k = {1'b0, last_cim} + KW'(1) + KW'(i);
        if (k >= KW'(NUM_CIMS)) k = k - KW'(NUM_CIMS);
        if (!win_ok && req_eff[k[IW-1:0]]) begin
          win_ok  = 1'b1;
          win_idx = k[IW-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant_q  <= '0;
      gv_q     <= 1'b0;
      owner_q  <= '0;
      cur_idx  <= '0;
      last_cim <= IW'(NUM_CIMS - 1);
    end else begin
      unique case (state)
        IDLE, TURNAROUND: begin
          if (win_ok) begin
            state   <= GRANTED;
            grant_q <= NUM_REQ'(1) << win_idx;
            gv_q    <= 1'b1;
            owner_q <= win_idx;
            cur_idx <= win_idx;
            if (win_idx != IW'(NUM_CIMS)) last_cim <= win_idx;
          end else begin
            state <= IDLE;
          end
        end
        GRANTED: begin
          if (!bus.req[cur_idx] || revoke) begin
            state   <= TURNAROUND;
            grant_q <= '0;
            gv_q    <= 1'b0;
            owner_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter NUM_CIMS, default 64: number of CiM requesters; requester index NUM_CIMS is the master; NUM_REQ = NUM_CIMS+1.
REQ-002 Parameter MAX_HOLD, default 128: maximum cycles an owner keeps the bus while others wait.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  NUM_REQ  per-requester bus request, level; held high while requesting or owning.
REQ-006 grant  output  NUM_REQ  one-hot (or all-zero) bus-drive permission, registered.
REQ-007 grant_valid  output  1  high when grant is non-zero.
REQ-008 owner_idx  output  $clog2(NUM_REQ)  index of current owner, 0 when grant_valid low.
REQ-009 timeout_pulse  output  1  one-cycle pulse on forced revoke; tied 0 when BUS_ARB_TIMEOUT_EN is undefined.

Function
REQ-010 FSM states: IDLE, GRANTED, TURNAROUND; no other state is reachable.
REQ-011 IDLE: any req bit high at edge N -> GRANTED with grant to the winner visible after edge N (1-cycle latency); else stay IDLE, grant = 0.
REQ-012 Winner: master (req[NUM_CIMS]) has fixed priority over all CiMs; otherwise round-robin over CiMs, searching from (last_cim+1) mod NUM_CIMS upward with wrap.
REQ-013 last_cim updates only on a CiM grant; a master grant leaves it unchanged.
REQ-014 Arbitration is non-preemptive: a master request never revokes an active CiM owner.
REQ-015 GRANTED: grant held constant while req[owner] high; req[owner] low at an edge -> TURNAROUND, grant = 0 after that edge.
REQ-016 TURNAROUND lasts exactly one cycle with grant = 0 (tri-state bus float gap); the arbitration of REQ-011/012 is performed in TURNAROUND, giving GRANTED or IDLE.
REQ-017 An owner's release and its re-request are separated by at least the TURNAROUND cycle; a re-requesting CiM is last in round-robin order.
REQ-018 Request dropped in the same cycle grant first appears: treated as release, TURNAROUND on the next edge.
REQ-019 grant is never multi-hot; grant_valid == |grant; owner_idx consistent with grant every cycle.

Reset
REQ-020 rst high: grant = 0, grant_valid = 0, owner_idx = 0, timeout_pulse = 0 immediately (asynchronous), FSM = IDLE.
REQ-021 Reset values: last_cim = NUM_CIMS-1 (first CiM search starts at 0), hold counter = 0.
REQ-022 Reset asserted mid-grant drops the grant with no TURNAROUND; first grant after release follows REQ-011.

Configuration
REQ-023 Macro BUS_ARB_TIMEOUT_EN defined: hold counter counts cycles in GRANTED, cleared on each new grant; saturates at MAX_HOLD-1.
REQ-024 With BUS_ARB_TIMEOUT_EN, counter at MAX_HOLD-1 and any other req bit high -> forced revoke: TURNAROUND next edge, timeout_pulse high for that one cycle.
REQ-025 With BUS_ARB_TIMEOUT_EN, counter saturated and no other requester: owner keeps bus, no pulse.
REQ-026 Without BUS_ARB_TIMEOUT_EN: no hold counter logic, timeout_pulse constant 0, owner holds bus indefinitely.

Verification (bench: NUM_CIMS=4, MAX_HOLD=8)
REQ-027 Reset, req=5'b00100 at edge 1 -> grant=5'b00100, owner_idx=2 after edge 1; req drop at edge 4 -> grant=0 after edge 4 (TURNAROUND), IDLE after edge 5.
REQ-028 req=5'b11111 held -> grant order master(4), then after its release CiMs 0,1,2,3,0, each separated by one grant=0 cycle.
REQ-029 CiM 3 owns, master raises req[4] -> CiM 3 keeps grant until its release; master granted immediately after TURNAROUND.
REQ-030 BUS_ARB_TIMEOUT_EN, CiM 1 holds req, CiM 2 requests at grant cycle 0 -> revoke after 8 GRANTED cycles, timeout_pulse one cycle, grant=5'b00100 after TURNAROUND; CiM 1 alone -> no revoke, no pulse.
REQ-031 rst asserted while CiM 0 owns -> grant=0 same cycle; rst released with req=5'b00001 -> grant=5'b00001 one edge later.
REQ-032 Random req stream 10k cycles -> grant never multi-hot, grant_valid/owner_idx always consistent, every grant-owner change separated by one grant=0 cycle.
